// File: rtl/sr_mdu_pkg.sv
// Shared opcodes, FSM state type and helpers for the schoolRISCV multiply/divide unit.
package sr_mdu_pkg;

  localparam logic [2:0] MDU_MUL    = 3'd0;
  localparam logic [2:0] MDU_MULH   = 3'd1;
  localparam logic [2:0] MDU_MULHSU = 3'd2;
  localparam logic [2:0] MDU_MULHU  = 3'd3;
  localparam logic [2:0] MDU_DIV    = 3'd4;
  localparam logic [2:0] MDU_DIVU   = 3'd5;
  localparam logic [2:0] MDU_REM    = 3'd6;
  localparam logic [2:0] MDU_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_e;

  function automatic logic op_is_div(input logic [2:0] op);
    return op[2];
  endfunction

  // Which operands are interpreted as two's complement for a given funct3.
  function automatic logic op_a_signed(input logic [2:0] op);
    return (op == MDU_MULH) || (op == MDU_MULHSU) || (op == MDU_DIV) || (op == MDU_REM);
  endfunction

  function automatic logic op_b_signed(input logic [2:0] op);
    return (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
  endfunction

endpackage

// File: rtl/sr_mdu_divstep.sv
// One restoring-division step: trial subtract of the divisor from the shifted partial remainder.
module sr_mdu_divstep #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   rem_i,
  input  logic [XLEN-1:0] dvsr_i,
  output logic [XLEN-1:0] rem_o,
  output logic            q_o
);

  logic [XLEN:0] diff;

  assign diff  = rem_i - {1'b0, dvsr_i};
  assign q_o   = ~diff[XLEN];
  assign rem_o = q_o ? diff[XLEN-1:0] : rem_i[XLEN-1:0];

endmodule

// File: rtl/sr_mdu.sv
// Iterative RV32M multiply/divide unit: 32 shift-add or restoring-divide steps, then sign fix-up.
//
// state | meaning
// IDLE  | waiting for start; operands latched on accept
// CALC  | one multiply/divide iteration per cycle, 32 cycles
// FIX   | sign correction and output word select, result written
// DONE  | valid pulse for one cycle
module sr_mdu
  import sr_mdu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      oper,
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  output logic            busy,
  output logic            valid,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [2:0]        oper_q, oper_d;
  logic              negq_q, negq_d;
  logic              negr_q, negr_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              sa, sb;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              div_zero, div_ovf;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next, div_next, prod_fix;
  logic [XLEN-1:0]   ds_rem, quot, rem, fix_res;
  logic              ds_q;

  // acc holds {product_hi, multiplier} for multiply and {remainder, dividend/quotient} for divide.
  sr_mdu_divstep #(.XLEN(XLEN)) u_divstep (
    .rem_i  (acc_q[2*XLEN-1:XLEN-1]),
    .dvsr_i (opb_q),
    .rem_o  (ds_rem),
    .q_o    (ds_q)
  );

  always_comb begin
    sa       = op_a_signed(oper) & srcA[XLEN-1];
    sb       = op_b_signed(oper) & srcB[XLEN-1];
    mag_a    = sa ? -srcA : srcA;
    mag_b    = sb ? -srcB : srcB;
    div_zero = op_is_div(oper) && (srcB == '0);
    div_ovf  = ((oper == MDU_DIV) || (oper == MDU_REM)) && (srcA == INT_MIN) && (srcB == '1);

    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
    div_next = {ds_rem, acc_q[XLEN-2:0], ds_q};

    prod_fix = negq_q ? -acc_q : acc_q;
    quot     = negq_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem      = negr_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

    case (oper_q)
      MDU_MUL:                          fix_res = prod_fix[XLEN-1:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU:  fix_res = prod_fix[2*XLEN-1:XLEN];
      MDU_DIV, MDU_DIVU:                fix_res = quot;
      default:                          fix_res = rem;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    oper_d   = oper_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    result_d = result_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          oper_d = oper;
          cnt_d  = '0;
          opb_d  = mag_b;
          // Special cases are preloaded so the ordinary FIX select produces the answer.
          if (div_zero) begin
            acc_d   = {srcA, {XLEN{1'b1}}};
            negq_d  = 1'b0;
            negr_d  = 1'b0;
            state_d = ST_FIX;
          end else if (div_ovf) begin
            acc_d   = {{XLEN{1'b0}}, INT_MIN};
            negq_d  = 1'b0;
            negr_d  = 1'b0;
            state_d = ST_FIX;
          end else begin
            acc_d   = {{XLEN{1'b0}}, mag_a};
            negq_d  = sa ^ sb;
            negr_d  = sa;
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        acc_d = op_is_div(oper_q) ? div_next : mul_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(XLEN-1)) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        result_d = fix_res;
        state_d  = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (kill) begin
      state_d  = ST_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      oper_q   <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      oper_q   <= oper_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == ST_CALC) || (state_q == ST_FIX);
  assign valid  = (state_q == ST_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_sr_mdu.sv
// Randomised and directed checks of sr_mdu against an arithmetic reference model.
module tb_sr_mdu;

  logic        clk = 1'b0;
  logic        rst_n, start, kill;
  logic [2:0]  oper;
  logic [31:0] srcA, srcB;
  logic        busy, valid;
  logic [31:0] result;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] last_res;

  always #5 clk = ~clk;

  sr_mdu dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .kill   (kill),
    .oper   (oper),
    .srcA   (srcA),
    .srcB   (srcB),
    .busy   (busy),
    .valid  (valid),
    .result (result)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // RV32M semantics from plain integer arithmetic.
  function automatic logic [31:0] ref_mdu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int          sa, sb;
    longint      pa, pb;
    logic [63:0] p;
    sa = a;
    sb = b;
    case (op)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin pa = sa; pb = sb; p = pa * pb; return p[63:32]; end
      3'd2: begin pa = sa; pb = b;  p = pa * pb; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return sa / sb;
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return sa % sb;
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op < 3'd4) return 1'b0;
    if (b == 32'd0) return 1'b1;
    return (op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  endfunction

  // Launches one op in the current cycle; optionally re-asserts start at cycle restart_at.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int restart_at);
    int lat, nbusy, exp_lat;
    exp_lat = is_special(op, a, b) ? 2 : 34;
    oper = op; srcA = a; srcB = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    oper = 3'($urandom); srcA = $urandom; srcB = $urandom;
    lat = 0; nbusy = 0;
    for (int n = 1; n <= 60; n++) begin
      if (valid) begin lat = n; break; end
      if (busy) nbusy++;
      start = (n == restart_at);
      @(posedge clk); #1;
      start = 1'b0;
    end
    check_eq({tag, ".result"}, result, exp);
    check_eq({tag, ".latency"}, lat, exp_lat);
    check_eq({tag, ".busy_cycles"}, nbusy, exp_lat - 1);
    check_eq({tag, ".busy_at_valid"}, busy, 1'b0);
    @(posedge clk); #1;
    check_eq({tag, ".valid_pulse"}, valid, 1'b0);
    last_res = exp;
  endtask

  task automatic expect_quiet(input string tag);
    int nv;
    nv = 0;
    for (int n = 0; n < 40; n++) begin
      if (valid || busy) nv++;
      @(posedge clk); #1;
    end
    check_eq({tag, ".no_valid"}, nv, 0);
    check_eq({tag, ".result_kept"}, result, last_res);
  endtask

  task automatic kill_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int kill_at);
    oper = op; srcA = a; srcB = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n < kill_at; n++) begin
      @(posedge clk); #1;
    end
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    check_eq({tag, ".busy_after_kill"}, busy, 1'b0);
    expect_quiet(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    rst_n = 1'b0; start = 1'b0; kill = 1'b0; oper = '0; srcA = '0; srcB = '0;
    last_res = '0;
    #12;
    check_eq("reset.busy", busy, 1'b0);
    check_eq("reset.valid", valid, 1'b0);
    check_eq("reset.result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("mul_7x6",   3'd0, 32'd7, 32'd6, 32'd42, 0);
    run_op("mulh_m1",   3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 0);
    run_op("mulhu_m1",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
    run_op("mulhsu_m1", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("div_m7_2",  3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
    run_op("rem_m7_2",  3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0);
    run_op("divu_100_7", 3'd5, 32'd100, 32'd7, 32'd14, 0);
    run_op("remu_100_7", 3'd7, 32'd100, 32'd7, 32'd2, 0);
    run_op("divu_by0",  3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
    run_op("rem_by0",   3'd6, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 0);
    run_op("div_ovf",   3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    run_op("rem_ovf",   3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);
    run_op("div_restart", 3'd4, 32'd1000, 32'd7, 32'd142, 10);

    kill_op("kill_calc", 3'd4, 32'd1000, 32'd7, 20);
    kill_op("kill_fix",  3'd0, 32'd9, 32'd9, 33);
    kill_op("kill_special", 3'd5, 32'd9, 32'd0, 1);

    oper = 3'd0; srcA = 32'd4; srcB = 32'd4; start = 1'b1; kill = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; kill = 1'b0;
    check_eq("kill_start.busy", busy, 1'b0);
    expect_quiet("kill_start");

    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 15))
        0:       b = 32'd0;
        1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2, 3:    begin a = 32'($urandom_range(0, 255)) - 32'd128; b = 32'($urandom_range(0, 15)) - 32'd8; end
        default: ;
      endcase
      run_op($sformatf("rand%0d_op%0d", i, op), op, a, b, ref_mdu(op, a, b), 0);
    end

    oper = 3'd0; srcA = 32'h1234; srcB = 32'h5678; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst.busy", busy, 1'b0);
    check_eq("async_rst.valid", valid, 1'b0);
    check_eq("async_rst.result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last_res = '0;
    run_op("mul_3x5_after_rst", 3'd0, 32'd3, 32'd5, 32'd15, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sr_mdu.md
Name: sr_mdu

Overview:
- Iterative multiply/divide unit (RV32M) for the schoolRISCV core.
- Sits beside the integer ALU and takes the same register-file operands (srcA = rs1, srcB = rs2).
- Its result feeds the writeback mux.
- The control unit stalls the PC while busy is high; one operation is in flight at a time.

Parameters:
- XLEN, 32, operand/result width. Only 32 is supported.
- CNT_W, 6, iteration-counter width; must hold XLEN.

Ports:
- clk  input  1  core clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  launch operation; sampled only in IDLE
- kill  input  1  synchronous abort; forces IDLE next cycle
- oper  input  3  RV32M funct3: MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7
- srcA  input  32  rs1 operand, sampled on accepted start
- srcB  input  32  rs2 operand, sampled on accepted start
- busy  output  1  high from the cycle after an accepted start until valid
- valid  output  1  one-cycle pulse; result is good in that cycle
- result  output  32  registered result; held until the next accepted start

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; busy=0, valid=0, result=0; internal accumulators/counter cleared.
  - Reset mid-operation discards the operation; no valid pulse follows.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - start=1 accepts the operation: operands, oper and sign flags are latched.
  - Signed ops (MULH: both signed; MULHSU: srcA only; DIV/REM: both) latch operand magnitudes plus result-sign flags. Quotient sign = sA^sB; remainder sign = sA.
  - Next state is CALC, or FIX for the special cases below.
- CALC: one iteration per cycle, counter 0..31, then FIX.
  - Multiply: unsigned shift-add into a 64-bit product register.
  - Divide: restoring division. Shift {rem,quot} left by 1; subtract divisor from the upper half; keep the difference if non-negative and set quot bit 0.
- FIX (1 cycle):
  - Apply two's-complement sign correction.
  - Select the output: low/high product word, quotient or remainder.
  - Write result; go to DONE.
- DONE: valid=1 for exactly one cycle; busy=0 in that cycle; next state IDLE.
- Latency, start accepted in cycle 0:
  - busy high in cycles 1..33; valid in cycle 34 (32 CALC + FIX + DONE).
  - Back-to-back: a new start is accepted in the cycle after DONE.
- Special cases (skip CALC; valid in cycle 2):
  - Divide by zero: DIV/DIVU result = 0xFFFFFFFF; REM/REMU result = srcA.
  - Signed overflow (DIV/REM with srcA=0x80000000, srcB=0xFFFFFFFF): DIV = 0x80000000, REM = 0.
- start while not IDLE: ignored, with no effect on the in-flight operation.
- kill: highest priority after reset.
  - Any state goes to IDLE next cycle; busy=0; no valid pulse; result keeps its old value.
  - kill and start together in IDLE: kill wins and start is dropped.
- Width rules:
  - Product is 64-bit unsigned on magnitudes; negate the 64-bit value before selecting the high word.
  - Quotient and remainder are 32-bit; negation is modulo 2^32.
- MUL result equals the low 32 bits irrespective of operand signs.

Decomposition:
- Add MDU opcode defines to sr_cpu.vh alongside the ALU ones: MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_MULHU, MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU, matching funct3.
- Add state encodings as local parameters.
- Sub-module: none required. The datapath (product/remainder register, counter) and FSM fit in one module of ~200 lines.
- Optionally split out the 33-bit conditional subtract as sr_mdu_divstep (combinational).

Test Plan:
- MUL srcA=7, srcB=6 -> result 42; busy high cycles 1..33; valid only in cycle 34.
- MULH srcA=0xFFFFFFFF (-1), srcB=0xFFFFFFFF -> 0x00000000; MULHU same operands -> 0xFFFFFFFE; MULHSU -> 0xFFFFFFFF.
- DIV srcA=-7 (0xFFFFFFF9), srcB=2 -> 0xFFFFFFFD (-3); REM same operands -> 0xFFFFFFFF (-1); DIVU 100/7 -> 14; REMU -> 2.
- Divide by zero: DIVU 5/0 -> 0xFFFFFFFF, valid in cycle 2. Overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
- Start a DIV, assert start again in cycle 10 with different operands -> ignored, original result delivered. Assert kill in cycle 20 -> busy low in cycle 21, no valid, result unchanged.
- Pull rst_n low asynchronously mid-CALC -> busy, valid, result = 0 immediately. After release, a fresh MUL 3×5 -> 15 with full 34-cycle latency.
